capture_controller: RTL and testbench

//   Sequences acquisition for the logic-analyser display. Samples CHANNELS inputs at a programmable rate

---
 rtl/capture_controller.sv | 179 +++++++++++++++++
 tb/tb_capture_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/capture_controller.sv
// capture_controller
//   Acquisition sequencer for the logic-analyser display. Samples CHANNELS
//   probe inputs at a programmable rate into per-channel DATA_SIZE-bit shift
//   buffers. An arm / pre-trigger / wait-trigger / post-trigger / hold state
//   machine controls the capture. A finished capture is copied to data_out
//   only at frame_end, so the display never shows a torn frame.
//
//   Ports
//     clk        system clock
//     rst_n      synchronous reset, active low
//     sample_in  probe levels, already synchronised to clk
//     prescale   sample period minus one, in clk cycles
//     trig_ch    trigger source channel
//     trig_rise  1 = rising-edge trigger, 0 = falling-edge trigger
//     single     1 = stop after one capture, 0 = re-arm automatically
//     arm        start pulse; only acted on in IDLE
//     stop       abort pulse; acted on in every state
//     frame_end  one-cycle pulse at the start of vertical blanking
//     data_out   committed capture, channel c = [c*DATA_SIZE +: DATA_SIZE]
//     data_valid sticky flag, set at the first commit
//     state      0 IDLE, 1 PRETRIG, 2 WAIT_TRIG, 3 POSTTRIG, 4 HOLD

// Per-channel sample buffer. New samples enter at the MSB, so after a full
// capture index 0 holds the oldest sample.
module capture_channel #(
    parameter int DATA_SIZE = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 shift,
    input  logic                 sample,
    output logic [DATA_SIZE-1:0] shreg
);
    always_ff @(posedge clk) begin
        if (!rst_n)
            shreg <= '0;
        else if (shift)
            shreg <= {sample, shreg[DATA_SIZE-1:1]};
    end
endmodule

module capture_controller #(
    parameter int CHANNELS   = 4,
    parameter int DATA_SIZE  = 256,
    parameter int PRE_TRIG   = 64,
    parameter int PRESCALE_W = 16,
    localparam int TRIG_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNELS-1:0]           sample_in,
    input  logic [PRESCALE_W-1:0]         prescale,
    input  logic [TRIG_W-1:0]             trig_ch,
    input  logic                          trig_rise,
    input  logic                          single,
    input  logic                          arm,
    input  logic                          stop,
    input  logic                          frame_end,
    output logic [CHANNELS*DATA_SIZE-1:0] data_out,
    output logic                          data_valid,
    output logic [2:0]                    state
);
    localparam int CNT_W = $clog2(DATA_SIZE + 1);
    localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'(PRE_TRIG);
    localparam logic [CNT_W-1:0] POST_CNT = CNT_W'(DATA_SIZE - PRE_TRIG);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRETRIG  = 3'd1,
        S_WAITTRIG = 3'd2,
        S_POSTTRIG = 3'd3,
        S_HOLD     = 3'd4
    } state_t;

    state_t                             state_q, state_d;
    logic   [PRESCALE_W-1:0]            div_cnt, div_d;
    logic   [CNT_W-1:0]                 smp_cnt, smp_d, smp_inc;
    logic                               running, tick, shift_en, commit;
    logic                               trig_cur, trig_prev, trig_hit;
    logic   [CHANNELS-1:0][DATA_SIZE-1:0] shreg;

    assign state = state_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        capture_channel #(.DATA_SIZE(DATA_SIZE)) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .shift (shift_en),
            .sample(sample_in[c]),
            .shreg (shreg[c])
        );
    end

    // The newest stored sample of the trigger channel is the "previous" level
    // for edge detection, so no separate history register is needed.
    assign trig_cur  = sample_in[trig_ch];
    assign trig_prev = shreg[trig_ch][DATA_SIZE-1];
    assign trig_hit  = trig_rise ? (trig_cur & ~trig_prev) : (~trig_cur & trig_prev);
    assign smp_inc   = smp_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_cnt    <= '0;
            smp_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            div_cnt <= div_d;
            smp_cnt <= smp_d;
            if (commit) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_cnt;
        smp_d    = smp_cnt;
        commit   = 1'b0;
        running  = (state_q == S_PRETRIG) || (state_q == S_WAITTRIG) ||
                   (state_q == S_POSTTRIG);
        // >= keeps the divider from running away if prescale drops mid-count.
        tick     = running && (div_cnt >= prescale);
        shift_en = tick && !stop;

        if (running)
            div_d = tick ? '0 : div_cnt + PRESCALE_W'(1);

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = S_PRETRIG;
                    div_d   = '0;
                    smp_d   = '0;
                end
            end
            S_PRETRIG: begin
                if (tick) begin
                    smp_d = smp_inc;
                    if (smp_inc == PRE_CNT)
                        state_d = S_WAITTRIG;
                end
            end
            S_WAITTRIG: begin
                // The trigger sample itself is post-sample number 1.
                if (tick && trig_hit) begin
                    state_d = S_POSTTRIG;
                    smp_d   = CNT_W'(1);
                end
            end
            S_POSTTRIG: begin
                if (tick) begin
                    smp_d = smp_inc;
                    if (smp_inc == POST_CNT)
                        state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (frame_end) begin
                    commit  = 1'b1;
                    state_d = single ? S_IDLE : S_PRETRIG;
                    div_d   = '0;
                    smp_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a commit in the same cycle.
        if (stop) begin
            state_d = S_IDLE;
            commit  = 1'b0;
        end
    end
endmodule

// File: tb/tb_capture_controller.sv
module tb_capture_controller;
    localparam int CH = 4, DS = 256;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH-1:0]   sample_in;
    logic [15:0]     prescale;
    logic [1:0]      trig_ch;
    logic            trig_rise, single, arm, stop, frame_end;
    logic [CH*DS-1:0] data_out;
    logic            data_valid;
    logic [2:0]      state;

    int checks = 0;
    int errors = 0;

    capture_controller dut (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .prescale(prescale),
        .trig_ch(trig_ch), .trig_rise(trig_rise), .single(single), .arm(arm),
        .stop(stop), .frame_end(frame_end), .data_out(data_out),
        .data_valid(data_valid), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          mode;
        int          p;
        int          ch;
        bit          rise;
        bit          sgl;
        int          cyc;   // clk edges from arm until HOLD
        int          tcyc;  // clk edges from arm until POSTTRIG
        logic [63:0] lo;    // expected bits [63:0] of the trigger channel
        bit          b64;
        bit          top;
        int          st;    // state after the commit
    } vec_t;

    vec_t tbl[4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] pat(input int mode, input int k);
        logic [3:0] v;
        v = '0;
        case (mode)
            0: v[0] = (k >= 100);
            1: v[0] = (k >= 10 && k < 80) || (k >= 150);
            2: begin v[2] = (k < 120); v[0] = (k < 90); end
            default: v[1] = k[0];
        endcase
        return v;
    endfunction

    // Pulse arm, then feed pattern samples (each held prescale+1 cycles)
    // until HOLD, or abort with stop as soon as POSTTRIG is seen.
    task automatic run_capture(input int mode, input int p, input bit abort_post,
                               output int cyc, output int tcyc);
        cyc  = 0;
        tcyc = 0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("arm_to_pretrig", 64'(state), 64'd1);
        while (state != 3'd4 && cyc < 5000) begin
            sample_in = pat(mode, cyc / (p + 1));
            step();
            cyc++;
            if (tcyc == 0 && state == 3'd3) begin
                tcyc = cyc;
                if (abort_post) begin
                    stop = 1'b1;
                    step();
                    stop = 1'b0;
                    return;
                end
            end
        end
        chk("reach_hold", 64'(state), 64'd4);
    endtask

    task automatic commit_frame();
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
    endtask

    initial begin
        int cyc, tcyc;

        //             mode p ch rise sgl cyc   tcyc lo                      b64 top st
        tbl[0] = '{0, 0, 0, 1'b1, 1'b0, 292,  101, 64'h0,                  1'b1, 1'b1, 1};
        tbl[1] = '{1, 0, 0, 1'b1, 1'b0, 342,  151, 64'h0,                  1'b1, 1'b1, 1};
        tbl[2] = '{2, 3, 2, 1'b0, 1'b0, 1248, 484, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1};
        tbl[3] = '{3, 0, 1, 1'b1, 1'b1, 257,  66,  64'h5555_5555_5555_5555, 1'b1, 1'b0, 0};

        rst_n = 1'b0; arm = 1'b1; stop = 1'b0; frame_end = 1'b0;
        sample_in = '0; prescale = '0; trig_ch = '0; trig_rise = 1'b1; single = 1'b1;

        // Reset holds IDLE even with arm high.
        repeat (3) step();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_data_nonzero", 64'(data_out != '0), 64'd0);
        chk("rst_valid", 64'(data_valid), 64'd0);
        arm = 1'b0;
        rst_n = 1'b1;
        repeat (20) step();
        chk("idle_no_arm", 64'(state), 64'd0);

        for (int i = 0; i < 4; i++) begin
            prescale  = 16'(tbl[i].p);
            trig_ch   = 2'(tbl[i].ch);
            trig_rise = tbl[i].rise;
            single    = tbl[i].sgl;
            run_capture(tbl[i].mode, tbl[i].p, 1'b0, cyc, tcyc);
            chk($sformatf("v%0d_trig_cyc", i), 64'(tcyc), 64'(tbl[i].tcyc));
            chk($sformatf("v%0d_hold_cyc", i), 64'(cyc), 64'(tbl[i].cyc));
            if (i == 0) chk("valid_before_commit", 64'(data_valid), 64'd0);
            commit_frame();
            chk($sformatf("v%0d_state_after", i), 64'(state), 64'(tbl[i].st));
            chk($sformatf("v%0d_valid", i), 64'(data_valid), 64'd1);
            chk($sformatf("v%0d_lo", i), data_out[tbl[i].ch*DS +: 64], tbl[i].lo);
            chk($sformatf("v%0d_b64", i), 64'(data_out[tbl[i].ch*DS + 64]), 64'(tbl[i].b64));
            chk($sformatf("v%0d_top", i), 64'(data_out[tbl[i].ch*DS + DS-1]), 64'(tbl[i].top));
            if (tbl[i].st == 1) begin
                stop = 1'b1;
                step();
                stop = 1'b0;
                chk($sformatf("v%0d_stop_pretrig", i), 64'(state), 64'd0);
            end
        end

        // HOLD without frame_end keeps the previous capture (mode 3 on ch1).
        prescale = '0; trig_ch = 2'd0; trig_rise = 1'b1; single = 1'b1;
        run_capture(0, 0, 1'b0, cyc, tcyc);
        frame_end = 1'b0;
        repeat (1000) step();
        chk("hold_wait_state", 64'(state), 64'd4);
        chk("hold_wait_ch1", data_out[DS +: 64], 64'h5555_5555_5555_5555);
        chk("hold_wait_ch0", data_out[0 +: 64], 64'h0);

        // stop together with frame_end: abort wins, no commit.
        stop = 1'b1; frame_end = 1'b1;
        step();
        stop = 1'b0; frame_end = 1'b0;
        chk("stop_fe_state", 64'(state), 64'd0);
        chk("stop_fe_ch1", data_out[DS +: 64], 64'h5555_5555_5555_5555);

        // frame_end outside HOLD is ignored.
        commit_frame();
        chk("fe_idle_state", 64'(state), 64'd0);
        chk("fe_idle_ch1", data_out[DS +: 64], 64'h5555_5555_5555_5555);

        // stop during POSTTRIG discards the capture.
        run_capture(0, 0, 1'b1, cyc, tcyc);
        chk("abort_trig_cyc", 64'(tcyc), 64'd101);
        chk("abort_state", 64'(state), 64'd0);
        chk("abort_ch1", data_out[DS +: 64], 64'h5555_5555_5555_5555);
        chk("abort_valid", 64'(data_valid), 64'd1);

        // Re-arm after abort runs a complete capture from PRETRIG.
        run_capture(0, 0, 1'b0, cyc, tcyc);
        chk("rearm_hold_cyc", 64'(cyc), 64'd292);
        commit_frame();
        chk("rearm_state", 64'(state), 64'd0);
        chk("rearm_ch0_lo", data_out[0 +: 64], 64'h0);
        chk("rearm_ch0_b64", 64'(data_out[64]), 64'd1);
        chk("rearm_ch1_lo", data_out[DS +: 64], 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
